// File: rtl/imem_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
// Shared types and default sizes for the instruction-memory fetch controller.
//   fetch_state_t       : controller mode (IDLE, LOAD, RUN, HALT)
//   DEFAULT_WIDTH       : instruction word width
//   DEFAULT_INSTR_COUNT : memory depth in words (power of two)
//   DEFAULT_ADDR_W      : address width, log2 of the depth
//   DEFAULT_HALT_WORD   : instruction encoding that stops fetch
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_INSTR_COUNT = 32;
    localparam int DEFAULT_ADDR_W      = $clog2(DEFAULT_INSTR_COUNT);

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles every non-clock signal of the fetch controller.
//   loader  : start, load_start, load_valid, load_data, load_done,
//             load_count, load_err
//   memory  : mem_addr, mem_read_en, mem_write_en, mem_wdata, mem_instr
//   decode  : if_valid, if_ready, if_instr, if_pc
//   control : redirect_valid, redirect_target, halted
// master = the fetch controller, slave = the surrounding core/testbench.
// -----------------------------------------------------------------------------
interface imem_fetch_ctrl_if
    import mips_fetch_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) ();

    logic              start;
    logic              load_start;
    logic              load_valid;
    logic [WIDTH-1:0]  load_data;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              load_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_instr;

    logic              if_valid;
    logic              if_ready;
    logic [WIDTH-1:0]  if_instr;
    logic [ADDR_W-1:0] if_pc;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              halted;

    modport master (
        input  start, load_start, load_valid, load_data, load_done,
        input  mem_instr, if_ready, redirect_valid, redirect_target,
        output load_count, load_err,
        output mem_addr, mem_read_en, mem_write_en, mem_wdata,
        output if_valid, if_instr, if_pc, halted
    );

    modport slave (
        output start, load_start, load_valid, load_data, load_done,
        output mem_instr, if_ready, redirect_valid, redirect_target,
        input  load_count, load_err,
        input  mem_addr, mem_read_en, mem_write_en, mem_wdata,
        input  if_valid, if_instr, if_pc, halted
    );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_out_stage.sv
// -----------------------------------------------------------------------------
// fetch_out_stage
// Registered valid/ready output stage between the fetch port and decode.
//   clk, rst_n : clock, synchronous active-low reset
//   squash     : redirect taken - drop whatever is held
//   stop       : HALT word fetched - empty the stage, nothing captured
//   capture    : fetch slot this cycle - load instrIn/pcIn
//   instrIn    : word read from memory at pcIn
//   pcIn       : address of instrIn
//   ifValid    : stage holds an instruction for decode
//   ifInstr    : held instruction
//   ifPc       : address of the held instruction
// With none of squash/stop/capture the stage holds, which is how
// backpressure (valid && !ready) keeps the instruction stable.
// -----------------------------------------------------------------------------
module fetch_out_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              squash,
    input  logic              stop,
    input  logic              capture,
    input  logic [WIDTH-1:0]  instrIn,
    input  logic [ADDR_W-1:0] pcIn,
    output logic              ifValid,
    output logic [WIDTH-1:0]  ifInstr,
    output logic [ADDR_W-1:0] ifPc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifValid <= 1'b0;
            ifInstr <= '0;
            ifPc    <= '0;
        end else if (squash || stop) begin
            // Data bits are left as-is; only valid matters once emptied.
            ifValid <= 1'b0;
        end else if (capture) begin
            ifValid <= 1'b1;
            ifInstr <= instrIn;
            ifPc    <= pcIn;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Sequencer and sole owner of the instruction memory port (async read,
// separate write). LOAD writes loader words from address 0 upward; RUN walks
// the PC and hands instructions to decode through fetch_out_stage.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : imem_fetch_ctrl_if.master - loader, memory, decode and
//           redirect/halt signals (see the interface header)
// Memory strobes are decoded from the state alone, so a read and a write can
// never be issued in the same cycle.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               INSTR_COUNT = DEFAULT_INSTR_COUNT,
    parameter int               ADDR_W      = $clog2(INSTR_COUNT),
    parameter logic [WIDTH-1:0] HALT_WORD   = WIDTH'(DEFAULT_HALT_WORD)
) (
    input logic               clk,
    input logic               rst_n,
    imem_fetch_ctrl_if.master bus
);

    // Count value meaning "memory full"; needs the extra bit of loadCount.
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(INSTR_COUNT);

    fetch_state_t      state;
    fetch_state_t      nextState;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   loadCount;
    logic              loadErr;

    logic              ifValid;
    logic [WIDTH-1:0]  ifInstr;
    logic [ADDR_W-1:0] ifPc;

    logic              inRun;
    logic              canStart;
    logic              loadGo;
    logic              runGo;
    logic              fetch;
    logic              redirectHit;
    logic              haltHit;
    logic              canWrite;

    // start/load_start are only honoured while parked; load_start wins a tie.
    assign canStart    = (state == IDLE) || (state == HALT);
    assign loadGo      = canStart && bus.load_start;
    assign runGo       = canStart && bus.start && !bus.load_start;

    assign inRun       = (state == RUN);
    assign fetch       = inRun && (!ifValid || bus.if_ready);
    assign redirectHit = inRun && bus.redirect_valid;
    // A redirect on the same edge overrides the halt.
    assign haltHit     = fetch && !redirectHit && (bus.mem_instr == HALT_WORD);
    assign canWrite    = (state == LOAD) && bus.load_valid && (loadCount < FULL_COUNT);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        nextState = state;
        case (state)
            IDLE, HALT: begin
                if (bus.load_start) begin
                    nextState = LOAD;
                end else if (bus.start) begin
                    nextState = RUN;
                end
            end
            LOAD: begin
                if (bus.load_done) begin
                    nextState = IDLE;
                end
            end
            RUN: begin
                if (haltHit) begin
                    nextState = HALT;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (memory port)
    // -------------------------------------------------------------------------
    always_comb begin
        bus.mem_addr     = '0;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.mem_wdata    = '0;
        case (state)
            LOAD: begin
                bus.mem_addr     = loadCount[ADDR_W-1:0];
                bus.mem_wdata    = bus.load_data;
                bus.mem_write_en = canWrite;
            end
            RUN: begin
                bus.mem_addr    = pc;
                bus.mem_read_en = fetch;
            end
            default: ;
        endcase
    end

    assign bus.halted = (state == HALT);

    // -------------------------------------------------------------------------
    // Program counter: redirect beats halt beats fetch; otherwise hold.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (runGo) begin
            pc <= '0;
        end else if (redirectHit) begin
            pc <= bus.redirect_target;
        end else if (fetch && !haltHit) begin
            // Natural wrap at INSTR_COUNT since pc is exactly ADDR_W bits.
            pc <= pc + ADDR_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Load pointer and sticky overflow flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loadCount <= '0;
            loadErr   <= 1'b0;
        end else if (loadGo) begin
            loadCount <= '0;
            loadErr   <= 1'b0;
        end else if (canWrite) begin
            loadCount <= loadCount + (ADDR_W + 1)'(1);
        end else if ((state == LOAD) && bus.load_valid) begin
            // Word offered with memory already full: dropped, count holds.
            loadErr <= 1'b1;
        end
    end

    assign bus.load_count = loadCount;
    assign bus.load_err   = loadErr;

    // -------------------------------------------------------------------------
    // Output stage to decode
    // -------------------------------------------------------------------------
    fetch_out_stage #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) outStage (
        .clk     (clk),
        .rst_n   (rst_n),
        .squash  (redirectHit),
        .stop    (haltHit),
        .capture (fetch),
        .instrIn (bus.mem_instr),
        .pcIn    (pc),
        .ifValid (ifValid),
        .ifInstr (ifInstr),
        .ifPc    (ifPc)
    );

    assign bus.if_valid = ifValid;
    assign bus.if_instr = ifInstr;
    assign bus.if_pc    = ifPc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Drives imem_fetch_ctrl with loads and randomized runs. A behavioural
// memory sits on the memory port; a reference copy of the loaded program and
// an expected-PC walker predict the instruction stream decode must receive.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    localparam int          N    = 32;
    localparam int          AW   = 5;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural memory: async read, write on the clock edge.
    logic [31:0] benchMem [N];
    always @(posedge clk) begin
        if (bus.mem_write_en === 1'b1) begin
            benchMem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_instr = benchMem[bus.mem_addr];

    // Reference copy of what the loader put in memory.
    logic [31:0] refMem [N];
    logic [31:0] prog [$];

    int nAssert = 0;
    int nFail   = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    // Load prog[0..n-1]; words past the memory depth must be refused.
    task automatic load_words(input int n, input bit startToo, input bit doneWithLast);
        int expCount;
        bus.load_start = 1'b1;
        bus.start      = startToo;
        tick();
        bus.load_start = 1'b0;
        nAssert++;
        if (bus.load_count !== '0 || bus.load_err !== 1'b0) begin
            nFail++;
            $display("FAIL load_clear: count=%0d err=%b, expected count=0 err=0",
                     bus.load_count, bus.load_err);
        end
        for (int i = 0; i < n; i++) begin
            bus.start      = startToo && (i == 0);
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            bus.load_done  = doneWithLast && (i == n - 1);
            @(negedge clk);
            nAssert++;
            if (i < N) begin
                if (bus.mem_write_en !== 1'b1 || bus.mem_addr !== AW'(i) ||
                    bus.mem_wdata !== prog[i] || bus.mem_read_en !== 1'b0) begin
                    nFail++;
                    $display("FAIL load_write[%0d]: we=%b re=%b addr=%0d data=%h, expected we=1 re=0 addr=%0d data=%h",
                             i, bus.mem_write_en, bus.mem_read_en, bus.mem_addr, bus.mem_wdata, i, prog[i]);
                end
                refMem[i] = prog[i];
            end else if (bus.mem_write_en !== 1'b0) begin
                nFail++;
                $display("FAIL load_overflow_write[%0d]: we=%b, expected we=0", i, bus.mem_write_en);
            end
            tick();
        end
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        if (!doneWithLast) begin
            bus.load_done = 1'b1;
            tick();
        end
        bus.load_done = 1'b0;
        expCount = (n < N) ? n : N;
        nAssert++;
        if (bus.load_count !== (AW + 1)'(expCount) || bus.load_err !== (n > N)) begin
            nFail++;
            $display("FAIL load_result: count=%0d err=%b, expected count=%0d err=%b",
                     bus.load_count, bus.load_err, expCount, (n > N));
        end
        // Back in IDLE: a stray loader word must not write, nothing is read.
        bus.load_valid = 1'b1;
        #1;
        nAssert++;
        if (bus.mem_write_en !== 1'b0 || bus.mem_read_en !== 1'b0) begin
            nFail++;
            $display("FAIL idle_after_load: we=%b re=%b, expected we=0 re=0",
                     bus.mem_write_en, bus.mem_read_en);
        end
        bus.load_valid = 1'b0;
    endtask

    // Start a run and follow it to HALT against the expected stream.
    // forceCyc >= 0: stall decode from cycle 1 and redirect to forceTgt
    // at cycle forceCyc, so a held instruction gets squashed.
    task automatic run_stream(input int readyPct, input int nRedir, input int haltRedir,
                              input int maxTarget, input int forceCyc, input int forceTgt);
        int          expPc;
        int          bubble;
        int          redirLeft;
        int          haltLeft;
        int          tgt;
        bit          held;
        bit          done;
        bit          redirNow;
        logic [31:0]   heldInstr;
        logic [AW-1:0] heldPc;
        logic [AW-1:0] heldAddr;
        expPc     = 0;
        bubble    = 1;
        held      = 1'b0;
        done      = 1'b0;
        redirLeft = nRedir;
        haltLeft  = haltRedir;
        tgt       = 0;
        heldInstr = '0;
        heldPc    = '0;
        heldAddr  = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            if (bubble == 1) begin
                nAssert++;
                if (bus.if_valid !== 1'b0) begin
                    nFail++;
                    $display("FAIL bubble_empty: if_valid=%b, expected 0", bus.if_valid);
                end
            end else if (bubble == 2) begin
                nAssert++;
                if (!((bus.if_valid === 1'b1 && bus.if_pc === AW'(expPc)) ||
                      (bus.halted === 1'b1 && refMem[expPc] === HALT))) begin
                    nFail++;
                    $display("FAIL bubble_fill: if_valid=%b if_pc=%0d halted=%b, expected valid pc=%0d",
                             bus.if_valid, bus.if_pc, bus.halted, expPc);
                end
            end
            if (held) begin
                nAssert++;
                if (bus.if_valid !== 1'b1 || bus.if_instr !== heldInstr ||
                    bus.if_pc !== heldPc || bus.mem_addr !== heldAddr) begin
                    nFail++;
                    $display("FAIL hold_stable: valid=%b instr=%h pc=%0d addr=%0d, expected valid=1 instr=%h pc=%0d addr=%0d",
                             bus.if_valid, bus.if_instr, bus.if_pc, bus.mem_addr, heldInstr, heldPc, heldAddr);
                end
            end
            if (bus.halted === 1'b1) begin
                nAssert++;
                if (refMem[expPc] !== HALT || bus.if_valid !== 1'b0) begin
                    nFail++;
                    $display("FAIL halt_point: halted with expected pc=%0d word=%h if_valid=%b, expected word=%h if_valid=0",
                             expPc, refMem[expPc], bus.if_valid, HALT);
                end
                done = 1'b1;
            end else begin
                redirNow     = 1'b0;
                bus.if_ready = (int'($urandom_range(0, 99)) < readyPct);
                if (cyc > 0 && cyc < forceCyc) bus.if_ready = 1'b0;
                #1;
                if (cyc == forceCyc) begin
                    redirNow     = 1'b1;
                    tgt          = forceTgt;
                    bus.if_ready = 1'b0;
                end else if (haltLeft > 0 && bus.mem_read_en === 1'b1 && bus.mem_instr === HALT) begin
                    redirNow = 1'b1;
                    tgt      = 0;
                    haltLeft--;
                end else if (redirLeft > 0 && $urandom_range(0, 99) < 8) begin
                    redirNow = 1'b1;
                    tgt      = int'($urandom_range(0, maxTarget));
                    redirLeft--;
                end
                bus.redirect_valid  = redirNow;
                bus.redirect_target = AW'(tgt);
                @(negedge clk);
                if (redirNow) begin
                    expPc  = tgt;
                    held   = 1'b0;
                    bubble = 1;
                end else begin
                    if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
                        nAssert++;
                        if (bus.if_pc !== AW'(expPc) || bus.if_instr !== refMem[expPc] ||
                            refMem[expPc] === HALT) begin
                            nFail++;
                            $display("FAIL accept: pc=%0d instr=%h, expected pc=%0d instr=%h (non-halt)",
                                     bus.if_pc, bus.if_instr, expPc, refMem[expPc]);
                        end
                        expPc = (expPc + 1) % N;
                        held  = 1'b0;
                    end else if (bus.if_valid === 1'b1) begin
                        held      = 1'b1;
                        heldInstr = bus.if_instr;
                        heldPc    = bus.if_pc;
                        heldAddr  = bus.mem_addr;
                    end else begin
                        held = 1'b0;
                    end
                    bubble = (bubble == 1) ? 2 : 0;
                end
                tick();
            end
        end
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        nAssert++;
        if (!done) begin
            nFail++;
            $display("FAIL run_timeout: halted=%b, expected halt within cycle budget", bus.halted);
        end
    endtask

    task automatic check_reset_values(input string tag);
        nAssert++;
        if (bus.if_valid !== 1'b0 || bus.if_pc !== '0 || bus.if_instr !== '0 ||
            bus.halted !== 1'b0 || bus.load_count !== '0 || bus.load_err !== 1'b0 ||
            bus.mem_read_en !== 1'b0 || bus.mem_write_en !== 1'b0) begin
            nFail++;
            $display("FAIL %s: valid=%b pc=%0d instr=%h halted=%b count=%0d err=%b re=%b we=%b, expected all zero",
                     tag, bus.if_valid, bus.if_pc, bus.if_instr, bus.halted,
                     bus.load_count, bus.load_err, bus.mem_read_en, bus.mem_write_en);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset_held");
        rst_n = 1'b1;
        tick();
        check_reset_values("reset_released");
    endtask

    task automatic test_load();
        prog = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, HALT};
        // start alongside load_start and during the first word: LOAD wins.
        load_words(4, 1'b1, 1'b0);
    endtask

    task automatic test_run_halt();
        run_stream(100, 0, 0, 3, -1, 0);
    endtask

    task automatic test_backpressure();
        prog.delete();
        for (int i = 0; i < 12; i++) prog.push_back(rand_word());
        prog.push_back(HALT);
        load_words(13, 1'b0, 1'b1);
        run_stream(35, 0, 0, 12, -1, 0);
        run_stream(60, 0, 0, 12, -1, 0);
    endtask

    task automatic test_redirect();
        prog.delete();
        for (int i = 0; i < 9; i++) prog.push_back(rand_word());
        prog.push_back(HALT);
        load_words(10, 1'b0, 1'b0);
        run_stream(100, 0, 0, 9, 3, 5);
        run_stream(60, 4, 0, 9, -1, 0);
    endtask

    task automatic test_halt_vs_redirect();
        prog = '{rand_word(), rand_word(), HALT};
        load_words(3, 1'b0, 1'b0);
        run_stream(100, 0, 1, 2, -1, 0);
    endtask

    task automatic test_overflow();
        prog.delete();
        for (int i = 0; i < 33; i++) prog.push_back(rand_word());
        prog[20] = HALT;
        load_words(33, 1'b0, 1'b0);
        // Redirect to 29 so the walk wraps 31 -> 0 before reaching HALT.
        run_stream(70, 3, 0, 31, 2, 29);
    endtask

    task automatic test_reset_mid_run();
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back(rand_word());
        prog.push_back(HALT);
        load_words(6, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.if_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_values("reset_mid_run");
        rst_n        = 1'b1;
        bus.if_ready = 1'b0;
        tick();
        run_stream(100, 0, 0, 5, -1, 0);
    endtask

    initial begin
        bus.start           = 1'b0;
        bus.load_start      = 1'b0;
        bus.load_valid      = 1'b0;
        bus.load_data       = '0;
        bus.load_done       = 1'b0;
        bus.if_ready        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;

        test_reset();
        test_load();
        test_run_halt();
        test_backpressure();
        test_redirect();
        test_halt_vs_redirect();
        test_overflow();
        test_reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
